// File: rtl/slr_pkg.sv
// Shared constants, FSM encodings and a saturating counter helper for the
// SLR frame extractor.
package slr_pkg;
    localparam logic [15:0] HDR_DEF  = 16'h0FF0;
    localparam logic [15:0] TAIL_DEF = 16'hEB90;

    typedef enum logic [1:0] {W_HUNT, W_PLD, W_TL} wr_state_t;
    typedef enum logic       {R_IDLE, R_EMIT}      rd_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/slr_frame_extract_if.sv
// Byte-in / framed-byte-out bus of the SLR frame extractor.
interface slr_frame_extract_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_eof;

    modport slave  (input  rx_data, rx_valid, out_ready,
                    output out_data, out_valid, out_sof, out_eof);
    modport master (output rx_data, rx_valid, out_ready,
                    input  out_data, out_valid, out_sof, out_eof);
endinterface

// File: rtl/slr_idx_fifo.sv
// Show-ahead synchronous FIFO holding the buffer base of each committed frame.
module slr_idx_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 16
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] q,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wp, rp;
    logic         do_push, do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign q       = mem[rp[PW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wp[PW-1:0]] <= push_data;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/slr_frame_extract.sv
// Hunts HDR/payload/TAIL frames in a UART byte stream, buffers validated
// payloads and replays each committed frame as a gap-free byte stream.
module slr_frame_extract import slr_pkg::*; #(
    parameter logic [15:0] HDR       = HDR_DEF,
    parameter logic [15:0] TAIL      = TAIL_DEF,
    parameter int          PLD_LEN   = 8,
    parameter bit          CHK_EN    = 1'b1,
    parameter int          BUF_AW    = 12,
    parameter int          IDX_DEPTH = 16,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic                clk_sys,
    input  logic                rst,
    slr_frame_extract_if.slave  bus,
    output logic [15:0]         frm_ok_cnt,
    output logic [15:0]         frm_err_cnt,
    output logic [15:0]         frm_drop_cnt
);
    // Pointers carry one extra bit so a completely full buffer is distinguishable.
    localparam int            PW     = BUF_AW + 1;
    localparam logic [PW-1:0] BUF_SZ = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [PW-1:0] PLEN_P = PW'(PLD_LEN);
    localparam int            LAST   = PLD_LEN + 3;

    wr_state_t         ws;
    rd_state_t         rs;
    logic [7:0]        mem [1 << BUF_AW];
    logic [7:0]        last_byte, sum, ram_q;
    logic [PW-1:0]     wr_ptr, rel_ptr, base, used;
    logic [6:0]        cnt, oidx;
    logic [15:0]       idle;
    logic              tail_hi_ok, chk_ok, push_q;
    logic              fifo_empty, fifo_full, fifo_pop;
    logic [BUF_AW-1:0] fifo_q, rd_addr, rd_addr_n;
    logic              wr_en, hdr_hit, room, abort, accept, load_pld;
    logic [7:0]        od;
    logic              ov, osof, oeof;

    assign hdr_hit = {last_byte, bus.rx_data} == HDR;
    assign used    = wr_ptr - rel_ptr;
    assign room    = ((BUF_SZ - used) >= PLEN_P) && !fifo_full;
    assign wr_en   = (ws == W_PLD) && bus.rx_valid;
    assign abort   = (ws != W_HUNT) && !bus.rx_valid && (idle == TIMEOUT - 16'd1);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            ws           <= W_HUNT;
            last_byte    <= '0;
            wr_ptr       <= '0;
            base         <= '0;
            cnt          <= '0;
            sum          <= '0;
            idle         <= '0;
            tail_hi_ok   <= 1'b0;
            chk_ok       <= 1'b0;
            push_q       <= 1'b0;
            frm_ok_cnt   <= '0;
            frm_err_cnt  <= '0;
            frm_drop_cnt <= '0;
        end else begin
            push_q <= 1'b0;
            if (push_q) frm_ok_cnt <= sat_inc(frm_ok_cnt);
            idle <= (ws == W_HUNT || bus.rx_valid) ? 16'd0 : idle + 16'd1;
            if (abort) begin
                ws          <= W_HUNT;
                wr_ptr      <= base;
                last_byte   <= '0;
                frm_err_cnt <= sat_inc(frm_err_cnt);
            end else if (bus.rx_valid) begin
                case (ws)
                    W_HUNT: begin
                        last_byte <= bus.rx_data;
                        if (hdr_hit) begin
                            if (room) begin
                                ws   <= W_PLD;
                                base <= wr_ptr;
                                cnt  <= '0;
                                sum  <= '0;
                            end else begin
                                frm_drop_cnt <= sat_inc(frm_drop_cnt);
                            end
                        end
                    end
                    W_PLD: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        cnt    <= cnt + 7'd1;
                        sum    <= sum + bus.rx_data;
                        if (cnt == 7'(PLD_LEN - 1)) begin
                            ws     <= W_TL;
                            cnt    <= '0;
                            chk_ok <= !CHK_EN || (sum == bus.rx_data);
                        end
                    end
                    W_TL: begin
                        cnt <= cnt + 7'd1;
                        if (cnt == 7'd0) begin
                            tail_hi_ok <= (bus.rx_data == TAIL[15:8]);
                        end else begin
                            ws        <= W_HUNT;
                            last_byte <= '0;
                            if (tail_hi_ok && bus.rx_data == TAIL[7:0] && chk_ok) begin
                                push_q <= 1'b1;
                            end else begin
                                wr_ptr      <= base;
                                frm_err_cnt <= sat_inc(frm_err_cnt);
                            end
                        end
                    end
                    default: ws <= W_HUNT;
                endcase
            end
        end
    end

    // The index entry stays in the FIFO until its eof byte is accepted, so the
    // frame being replayed still occupies one of the IDX_DEPTH slots.
    slr_idx_fifo #(.W(BUF_AW), .DEPTH(IDX_DEPTH)) u_idx (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .push      (push_q),
        .push_data (base[BUF_AW-1:0]),
        .pop       (fifo_pop),
        .q         (fifo_q),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign accept    = ov && bus.out_ready;
    assign load_pld  = (rs == R_EMIT) && accept && (oidx >= 7'd1) && (oidx <= 7'(PLD_LEN));
    assign fifo_pop  = (rs == R_EMIT) && accept && (oidx == 7'(LAST));
    // Read address runs one step ahead so ram_q always holds the next payload byte.
    assign rd_addr_n = (rs == R_IDLE) ? fifo_q : (load_pld ? rd_addr + 1'b1 : rd_addr);

    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wr_ptr[BUF_AW-1:0]] <= bus.rx_data;
        ram_q <= mem[rd_addr_n];
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            rs      <= R_IDLE;
            rd_addr <= '0;
            rel_ptr <= '0;
            oidx    <= '0;
            od      <= '0;
            ov      <= 1'b0;
            osof    <= 1'b0;
            oeof    <= 1'b0;
        end else begin
            rd_addr <= rd_addr_n;
            case (rs)
                R_IDLE: if (!fifo_empty) begin
                    rs   <= R_EMIT;
                    oidx <= '0;
                    ov   <= 1'b1;
                    od   <= HDR[15:8];
                    osof <= 1'b1;
                    oeof <= 1'b0;
                end
                R_EMIT: if (accept) begin
                    oidx <= oidx + 7'd1;
                    osof <= 1'b0;
                    if (oidx == 7'(LAST)) begin
                        rs      <= R_IDLE;
                        ov      <= 1'b0;
                        oeof    <= 1'b0;
                        rel_ptr <= rel_ptr + PLEN_P;
                    end else begin
                        oeof <= (oidx == 7'(LAST - 1));
                        if (oidx == 7'd0)                  od <= HDR[7:0];
                        else if (oidx <= 7'(PLD_LEN))      od <= ram_q;
                        else if (oidx == 7'(PLD_LEN + 1))  od <= TAIL[15:8];
                        else                               od <= TAIL[7:0];
                    end
                end
                default: rs <= R_IDLE;
            endcase
        end
    end

    assign bus.out_data  = od;
    assign bus.out_valid = ov;
    assign bus.out_sof   = osof;
    assign bus.out_eof   = oeof;
endmodule

// File: tb/tb_slr_frame_extract.sv
// Directed bench: expected frames are predicted from the framing rules into a
// byte queue and compared against the output stream every cycle.
module tb_slr_frame_extract;
    logic clk_sys = 1'b0;
    logic rst = 1'b1;
    always #5 clk_sys = ~clk_sys;

    slr_frame_extract_if bus0();
    slr_frame_extract_if bus1();
    logic [15:0] ok0, err0, drop0, ok1, err1, drop1;

    slr_frame_extract u_dut0 (.clk_sys(clk_sys), .rst(rst), .bus(bus0),
        .frm_ok_cnt(ok0), .frm_err_cnt(err0), .frm_drop_cnt(drop0));
    slr_frame_extract #(.BUF_AW(4)) u_dut1 (.clk_sys(clk_sys), .rst(rst), .bus(bus1),
        .frm_ok_cnt(ok1), .frm_err_cnt(err1), .frm_drop_cnt(drop1));

    logic [7:0] rxd = 8'h00;
    logic rxv = 1'b0, sel = 1'b0, rdy_base = 1'b1, rdy_rand = 1'b1, toggle = 1'b0;
    logic rdy, o_valid, o_sof, o_eof;
    logic [7:0] o_data;

    assign rdy            = rdy_base && (rdy_rand || !toggle);
    assign bus0.rx_data   = rxd;
    assign bus1.rx_data   = rxd;
    assign bus0.rx_valid  = rxv && !sel;
    assign bus1.rx_valid  = rxv && sel;
    assign bus0.out_ready = rdy;
    assign bus1.out_ready = rdy;
    assign o_valid = sel ? bus1.out_valid : bus0.out_valid;
    assign o_data  = sel ? bus1.out_data  : bus0.out_data;
    assign o_sof   = sel ? bus1.out_sof   : bus0.out_sof;
    assign o_eof   = sel ? bus1.out_eof   : bus0.out_eof;

    always @(posedge clk_sys) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    typedef struct { logic [7:0] d; logic sof; logic eof; } ob_t;
    ob_t exp_q[$];
    ob_t held, e;
    logic held_v = 1'b0, mid = 1'b0;
    int checks = 0, failures = 0;
    int m_ok = 0, m_err = 0, m_drop = 0, outstanding = 0, committed0 = 0;
    logic [7:0] pl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (rst) begin
            held_v = 1'b0;
            mid    = 1'b0;
        end else begin
            if (mid) chk("gap", o_valid, 1);
            if (o_valid) begin
                if (held_v) begin
                    chk("hold_data", o_data, held.d);
                    chk("hold_sof", o_sof, held.sof);
                    chk("hold_eof", o_eof, held.eof);
                end
                if (rdy) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_byte: got %02h while no byte is expected", o_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", o_data, e.d);
                        chk("out_sof", o_sof, e.sof);
                        chk("out_eof", o_eof, e.eof);
                        mid = !e.eof;
                        if (e.eof) outstanding--;
                    end
                end else begin
                    held_v = 1'b1;
                    held   = '{o_data, o_sof, o_eof};
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rxd = b;
        rxv = 1'b1;
        tick(1);
        rxv = 1'b0;
        tick(gap);
    endtask

    function automatic void mk(input logic [7:0] b, input logic bad);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 7; i++) begin
            pl[i] = b + 8'(i);
            s     = s + pl[i];
        end
        pl[7] = bad ? s + 8'h01 : s;
    endfunction

    task automatic send_frame(input logic [15:0] tail, input int gap);
        int  s = 0;
        int  bufsz = sel ? 16 : 4096;
        logic good, cap;
        for (int i = 0; i < 7; i++) s += int'(pl[i]);
        good = (tail == 16'hEB90) && (s[7:0] == pl[7]);
        cap  = (outstanding < 16) && ((outstanding + 1) * 8 <= bufsz);
        send_byte(8'h0F, gap);
        send_byte(8'hF0, gap);
        for (int i = 0; i < 8; i++) send_byte(pl[i], gap);
        send_byte(tail[15:8], gap);
        send_byte(tail[7:0], 0);
        if (!cap) m_drop++;
        else if (!good) m_err++;
        else begin
            m_ok++;
            outstanding++;
            if (!sel) committed0++;
            exp_q.push_back('{8'h0F, 1'b1, 1'b0});
            exp_q.push_back('{8'hF0, 1'b0, 1'b0});
            for (int i = 0; i < 8; i++) exp_q.push_back('{pl[i], 1'b0, 1'b0});
            exp_q.push_back('{8'hEB, 1'b0, 1'b0});
            exp_q.push_back('{8'h90, 1'b0, 1'b1});
        end
        tick(gap);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 3000) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d bytes still pending, required 0", tag, exp_q.size());
        end
        tick(5);
    endtask

    task automatic check_counts(input string tag);
        tick(3);
        chk({tag, "_ok"},   sel ? ok1 : ok0,     m_ok);
        chk({tag, "_err"},  sel ? err1 : err0,   m_err);
        chk({tag, "_drop"}, sel ? drop1 : drop0, m_drop);
    endtask

    initial begin
        tick(3);
        chk("rst_valid", bus0.out_valid, 0);
        chk("rst_sof", bus0.out_sof, 0);
        chk("rst_eof", bus0.out_eof, 0);
        chk("rst_data", bus0.out_data, 0);
        chk("rst_ok", ok0, 0);
        chk("rst_err", err0, 0);
        chk("rst_drop", drop0, 0);
        chk("rst_valid1", bus1.out_valid, 0);
        rst = 1'b0;
        tick(2);

        pl = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
        send_frame(16'hEB90, 0);
        drain("good");
        check_counts("good");
        chk("good_ok_lit", ok0, 1);

        pl[7] = 8'h16;
        send_frame(16'hEB90, 0);
        toggle = 1'b1;
        mk(8'h30, 1'b0);
        send_frame(16'hEB90, 1);
        drain("badchk");
        toggle = 1'b0;
        check_counts("badchk");
        chk("badchk_err_lit", err0, 1);
        chk("badchk_ok_lit", ok0, 2);

        mk(8'h41, 1'b0);
        send_frame(16'hEB91, 0);
        send_byte(8'h0F, 0);
        mk(8'h50, 1'b0);
        send_frame(16'hEB90, 0);
        drain("garbage");
        check_counts("garbage");
        chk("garbage_ok_lit", ok0, 3);
        chk("garbage_err_lit", err0, 2);

        send_byte(8'h0F, 0);
        send_byte(8'hF0, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i), 0);
        tick(50005);
        m_err++;
        chk("timeout_wr_ptr", u_dut0.wr_ptr[11:0], (committed0 * 8) % 4096);
        check_counts("timeout");
        chk("timeout_err_lit", err0, 3);
        mk(8'h80, 1'b0);
        send_frame(16'hEB90, 0);
        drain("after_to");
        check_counts("after_to");

        rdy_base = 1'b0;
        for (int f = 0; f < 17; f++) begin
            mk(8'h60 + 8'(f * 4), 1'b0);
            send_frame(16'hEB90, 0);
        end
        check_counts("stall");
        chk("stall_drop_lit", drop0, 1);
        chk("stall_ok_lit", ok0, 20);
        rdy_base = 1'b1;
        drain("stall");

        sel = 1'b1;
        m_ok = 0; m_err = 0; m_drop = 0; outstanding = 0;
        for (int f = 0; f < 6; f++) begin
            mk(8'(f * 40), 1'b0);
            send_frame(16'hEB90, 3);
        end
        drain("wrap");
        check_counts("wrap");
        chk("wrap_ok_lit", ok1, 6);

        sel = 1'b0;
        send_byte(8'h0F, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h01, 0);
        rst = 1'b1;
        tick(1);
        chk("midrst_valid", bus0.out_valid, 0);
        chk("midrst_ok", ok0, 0);
        chk("midrst_err", err0, 0);
        chk("midrst_drop", drop0, 0);
        chk("midrst_wr_ptr", u_dut0.wr_ptr, 0);
        rst = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
